// File: rtl/dcache_controller.sv
// dcache_controller: direct-mapped write-back write-allocate data cache.
// Hits complete combinationally in IDLE; misses evict (if dirty) and refill a block.
module dcache_controller #(
    parameter int ADDR_W   = 8,
    parameter int INDEX_W  = 3,
    parameter int OFFSET_W = 2,
    localparam int TAG_W   = ADDR_W - INDEX_W - OFFSET_W,
    localparam int NB      = 1 << INDEX_W
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic                     read,
    input  logic                     write,
    input  logic [ADDR_W-1:0]        address,
    input  logic [7:0]               writedata,
    output logic [7:0]               readdata,
    output logic                     busywait,
    output logic                     mem_read,
    output logic                     mem_write,
    output logic [TAG_W+INDEX_W-1:0] mem_address,
    output logic [31:0]              mem_writedata,
    input  logic [31:0]              mem_readdata,
    input  logic                     mem_busywait
);
    typedef enum logic [1:0] {IDLE, MEM_WRITE, MEM_READ, UPDATE} state_t;
    state_t state;
    logic [31:0] data [NB];
    logic [TAG_W-1:0] tags [NB];
    logic [NB-1:0] valid, dirty;
    logic [31:0] fill;
    logic [TAG_W-1:0] tag;
    logic [INDEX_W-1:0] index;
    logic [OFFSET_W-1:0] offset;
    logic hit, idle, req;
    assign {tag, index, offset} = address;
    assign hit = valid[index] && tags[index] == tag;
    assign idle = state == IDLE;
    assign req = read | write;
    // Gated by RESET so an in-flight stall is released the instant reset asserts.
    assign busywait = RESET && req && !(idle && hit);
    assign readdata = RESET ? data[index][{offset, 3'b000} +: 8] : 8'h00;
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state         <= IDLE;
            valid         <= '0;
            dirty         <= '0;
            mem_read      <= 1'b0;
            mem_write     <= 1'b0;
            mem_address   <= '0;
            mem_writedata <= '0;
            fill          <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req && hit) begin
                        if (write) dirty[index] <= 1'b1;
                    end else if (req && valid[index] && dirty[index]) begin
                        state         <= MEM_WRITE;
                        mem_write     <= 1'b1;
                        mem_address   <= {tags[index], index};
                        mem_writedata <= data[index];
                    end else if (req) begin
                        state       <= MEM_READ;
                        mem_read    <= 1'b1;
                        mem_address <= {tag, index};
                    end
                end
                MEM_WRITE: if (!mem_busywait) begin
                    state       <= MEM_READ;
                    mem_write   <= 1'b0;
                    mem_read    <= 1'b1;
                    mem_address <= {tag, index};
                end
                MEM_READ: if (!mem_busywait) begin
                    state    <= UPDATE;
                    mem_read <= 1'b0;
                    fill     <= mem_readdata;
                end
                UPDATE: begin
                    state        <= IDLE;
                    valid[index] <= 1'b1;
                    dirty[index] <= 1'b0;
                end
            endcase
        end
    end
    // Storage arrays carry no reset; valid bits alone define their contents.
    always_ff @(posedge CLK) begin
        if (state == UPDATE) begin
            data[index] <= fill;
            tags[index] <= tag;
        end else if (idle && hit && write) begin
            data[index][{offset, 3'b000} +: 8] <= writedata;
        end
    end
endmodule
